// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - rectangle/pixel/clear fill engine for a framebuffer write port
module fb_rect_fill #(
    parameter int FB_WIDTH  = 214,
    parameter int FB_HEIGHT = 160
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_x0,
    input  logic [7:0]  cmd_x1,
    input  logic [7:0]  cmd_y0,
    input  logic [7:0]  cmd_y1,
    input  logic [2:0]  cmd_color,
    output logic        fb_we,
    output logic [15:0] fb_waddr,
    output logic [2:0]  fb_wdata,
    input  logic        fb_wait,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0]  X_MAX = 8'(FB_WIDTH - 1);
    localparam logic [7:0]  Y_MAX = 8'(FB_HEIGHT - 1);
    localparam logic [15:0] W16   = 16'(FB_WIDTH);

    localparam logic [1:0] OP_PIXEL = 2'd0;
    localparam logic [1:0] OP_RECT  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  x0_q, x0_d, x1_q, x1_d;
    logic [7:0]  y0_q, y0_d, y1_q, y1_d;
    logic [2:0]  color_q, color_d;
    logic [7:0]  x_cur_q, x_cur_d;
    logic [7:0]  y_cur_q, y_cur_d;
    logic [15:0] row_base_q, row_base_d;
    logic [7:0]  x1_clip, y1_clip;

    // Clipped bounds are only meaningful in SETUP, where they are written back.
    assign x1_clip = (x1_q > X_MAX) ? X_MAX : x1_q;
    assign y1_clip = (y1_q > Y_MAX) ? Y_MAX : y1_q;

    // Outputs that follow directly from the registered state and raster position.
    assign cmd_ready = (state_q == IDLE) && !rst_sync;
    assign busy      = (state_q != IDLE);
    assign fb_waddr  = row_base_q + {8'd0, x_cur_q};
    assign fb_wdata  = color_q;

    // Next-state, command capture and raster stepping.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        color_d    = color_q;
        x_cur_d    = x_cur_q;
        y_cur_d    = y_cur_q;
        row_base_d = row_base_q;
        fb_we      = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    color_d = cmd_color;
                    x0_d    = cmd_x0;
                    x1_d    = cmd_x1;
                    y0_d    = cmd_y0;
                    y1_d    = cmd_y1;
                    if (cmd_op == OP_PIXEL) begin
                        x1_d = cmd_x0;
                        y1_d = cmd_y0;
                    end else if (cmd_op == OP_CLEAR) begin
                        x0_d = 8'd0;
                        x1_d = X_MAX;
                        y0_d = 8'd0;
                        y1_d = Y_MAX;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                x1_d = x1_clip;
                y1_d = y1_clip;
                if (op_q == OP_RSVD || x0_q > x1_clip || y0_q > y1_clip) begin
                    state_d = DONE;
                end else begin
                    row_base_d = {8'd0, y0_q} * W16;
                    x_cur_d    = x0_q;
                    y_cur_d    = y0_q;
                    state_d    = DRAW;
                end
            end
            DRAW: begin
                fb_we = 1'b1;
                if (!fb_wait) begin
                    if (x_cur_q < x1_q) begin
                        x_cur_d = x_cur_q + 8'd1;
                    end else if (y_cur_q == y1_q) begin
                        state_d = DONE;
                    end else begin
                        x_cur_d    = x0_q;
                        y_cur_d    = y_cur_q + 8'd1;
                        row_base_d = row_base_q + W16;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q    <= IDLE;
            op_q       <= OP_PIXEL;
            x0_q       <= 8'd0;
            x1_q       <= 8'd0;
            y0_q       <= 8'd0;
            y1_q       <= 8'd0;
            color_q    <= 3'd0;
            x_cur_q    <= 8'd0;
            y_cur_q    <= 8'd0;
            row_base_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            color_q    <= color_d;
            x_cur_q    <= x_cur_d;
            y_cur_q    <= y_cur_d;
            row_base_q <= row_base_d;
        end
    end

    // RECT carries no special handling beyond the shared path.
    logic unused_rect;
    assign unused_rect = (OP_RECT == 2'd1);

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - directed self-checking bench for fb_rect_fill
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst_sync = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_x0 = 8'd0, cmd_x1 = 8'd0, cmd_y0 = 8'd0, cmd_y1 = 8'd0;
    logic [2:0]  cmd_color = 3'd0;
    logic        fb_we;
    logic [15:0] fb_waddr;
    logic [2:0]  fb_wdata;
    logic        fb_wait = 1'b0;
    logic        busy;
    logic        done;

    fb_rect_fill dut (
        .clk(clk), .rst_sync(rst_sync),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color),
        .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_wait(fb_wait),
        .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] wa[$];
    logic [2:0]  wd[$];
    int          wc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          acc_cyc  = -1;
    int          hold_err = 0;
    logic        hold_valid = 1'b0;
    logic [15:0] hold_addr = 16'd0;
    logic        wait_tog = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // fb_wait driver: low, or toggling every cycle when wait_tog is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fb_wait = wait_tog ? ~fb_wait : 1'b0;
        end
    end

    // Observe the write port, done pulses and acceptance away from the active edge
    always @(negedge clk) begin
        if (fb_we && !fb_wait) begin
            wa.push_back(fb_waddr);
            wd.push_back(fb_wdata);
            wc.push_back(cyc);
        end
        if (hold_valid && fb_we && fb_waddr != hold_addr) hold_err++;
        hold_valid = fb_we && fb_wait;
        hold_addr  = fb_waddr;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] x1,
                         input logic [7:0] y0, input logic [7:0] y1, input logic [2:0] col);
        bit ok;
        wa.delete(); wd.delete(); wc.delete();
        ok = 0;
        @(posedge clk); #1;
        cmd_op = op; cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1; cmd_color = col;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int exp_a[8];
        int mx;
        int ord_err;
        int dat_err;
        int n;
        int w0;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", fb_waddr, 0);
        check("rst_data", fb_wdata, 0);
        @(posedge clk); #1;
        rst_sync = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // PIXEL (5,2)
        issue(2'd0, 8'd5, 8'd99, 8'd2, 8'd99, 3'b101);
        wait_done(20);
        check("pix_count", wa.size(), 1);
        if (wa.size() >= 1) begin
            check("pix_addr", wa[0], 433);
            check("pix_data", wd[0], 5);
            check("pix_lat", wc[0] - acc_cyc, 2);
        end
        check("pix_done_lat", done_cyc - acc_cyc, 3);

        // RECT (10,1)-(12,2)
        issue(2'd1, 8'd10, 8'd12, 8'd1, 8'd2, 3'b010);
        wait_done(30);
        exp_a = '{224, 225, 226, 438, 439, 440, 0, 0};
        check("rect_count", wa.size(), 6);
        if (wa.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("rect_addr%0d", i), wa[i], exp_a[i]);
                check($sformatf("rect_cyc%0d", i), wc[i] - acc_cyc, 2 + i);
            end
            check("rect_data", wd[5], 2);
        end
        check("rect_done_lat", done_cyc - acc_cyc, 8);

        // Clipped RECT
        issue(2'd1, 8'd210, 8'd255, 8'd158, 8'd255, 3'b111);
        wait_done(40);
        exp_a = '{34022, 34023, 34024, 34025, 34236, 34237, 34238, 34239};
        check("clip_count", wa.size(), 8);
        if (wa.size() == 8) begin
            for (int i = 0; i < 8; i++) check($sformatf("clip_addr%0d", i), wa[i], exp_a[i]);
        end
        mx = 0;
        foreach (wa[i]) if (wa[i] > mx) mx = wa[i];
        check("clip_max", mx, 34239);

        // Empty RECT and reserved op
        issue(2'd1, 8'd20, 8'd10, 8'd0, 8'd0, 3'b001);
        wait_done(20);
        check("empty_count", wa.size(), 0);
        check("empty_done_lat", done_cyc - acc_cyc, 2);
        issue(2'd3, 8'd0, 8'd5, 8'd0, 8'd5, 3'b001);
        wait_done(20);
        check("rsvd_count", wa.size(), 0);
        check("rsvd_done_lat", done_cyc - acc_cyc, 2);

        // CLEAR with toggling fb_wait
        hold_err = 0;
        wait_tog = 1'b1;
        issue(2'd2, 8'd7, 8'd1, 8'd9, 8'd3, 3'b110);
        wait_done(80000);
        wait_tog = 1'b0;
        check("clr_count", wa.size(), 34240);
        ord_err = 0;
        dat_err = 0;
        n = (wa.size() < 34240) ? wa.size() : 34240;
        for (int i = 0; i < n; i++) begin
            if (int'(wa[i]) != i) ord_err++;
            if (wd[i] != 3'b110) dat_err++;
        end
        check("clr_order", ord_err, 0);
        check("clr_data", dat_err, 0);
        check("clr_hold", hold_err, 0);
        repeat (2) @(negedge clk);

        // Reset during CLEAR at pixel 100
        issue(2'd2, 8'd0, 8'd0, 8'd0, 8'd0, 3'b011);
        for (int i = 0; i < 200; i++) begin
            if (wa.size() >= 100) break;
            @(negedge clk);
        end
        check("abort_reach100", wa.size(), 100);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_sync = 1'b1;
        @(posedge clk); #1;
        rst_sync = 1'b0;
        @(negedge clk);
        check("abort_we", fb_we, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        w0 = wa.size();
        repeat (10) @(negedge clk);
        check("abort_nowrite", wa.size(), w0);
        check("abort_nodone", done_cnt, d0);

        issue(2'd0, 8'd5, 8'd5, 8'd2, 8'd2, 3'b100);
        wait_done(20);
        check("post_count", wa.size(), 1);
        if (wa.size() >= 1) begin
            check("post_addr", wa[0], 433);
            check("post_data", wd[0], 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill.md
FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 Parameter FB_WIDTH, default 214, framebuffer pixels per line.
REQ-002 Parameter FB_HEIGHT, default 160, framebuffer lines.
REQ-003 clk  input  1  system clock, 50MHz; sole clock; all logic on posedge clk.
REQ-004 rst_sync  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  2  0=PIXEL, 1=RECT, 2=CLEAR, 3=reserved.
REQ-008 cmd_x0, cmd_x1  input  8 each  inclusive column bounds.
REQ-009 cmd_y0, cmd_y1  input  8 each  inclusive line bounds.
REQ-010 cmd_color  input  3  pixel colour {r,g,b}.
REQ-011 fb_we  output  1  framebuffer write strobe.
REQ-012 fb_waddr  output  16  write address = y*FB_WIDTH + x.
REQ-013 fb_wdata  output  3  write colour.
REQ-014 fb_wait  input  1  framebuffer write port busy; write not taken this cycle.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse on command completion.

Function
REQ-017 States SHALL be IDLE, SETUP, DRAW, DONE.
REQ-018 cmd_ready SHALL equal (state==IDLE); a command is accepted in a cycle where cmd_valid and cmd_ready are both high.
REQ-019 On acceptance, op, bounds and colour SHALL be registered and state SHALL go IDLE->SETUP; inputs are ignored after acceptance.
REQ-020 PIXEL SHALL use x1:=x0, y1:=y0; CLEAR SHALL use (0,0)-(FB_WIDTH-1,FB_HEIGHT-1) and colour cmd_color.
REQ-021 Reserved op SHALL be accepted, perform no write, and complete via SETUP->DONE.
REQ-022 In SETUP, x1 SHALL clip to FB_WIDTH-1 and y1 to FB_HEIGHT-1; if x0>clipped x1 or y0>clipped y1 the command is empty and SETUP->DONE with no write.
REQ-023 Otherwise SETUP SHALL load row_base=y0*FB_WIDTH (16-bit, constant multiply/shift-add, no divider), x_cur=x0, y_cur=y0, then go to DRAW.
REQ-024 In DRAW, fb_we SHALL be high every cycle, fb_waddr=row_base+x_cur, fb_wdata=colour.
REQ-025 A write is taken when fb_we & ~fb_wait; while fb_wait is high fb_waddr/fb_wdata/x_cur/y_cur SHALL hold.
REQ-026 On a taken write: if x_cur<x1, x_cur+=1; else x_cur=x0, y_cur+=1, row_base+=FB_WIDTH.
REQ-027 A taken write at (x1,y1) SHALL be the last; next state DONE.
REQ-028 Throughput SHALL be one pixel per cycle with fb_wait low; latency: acceptance cycle N, first fb_we at cycle N+2, done at cycle after last taken write.
REQ-029 DONE SHALL last one cycle with done=1, then go to IDLE; a new command is acceptable the following cycle.
REQ-030 fb_we SHALL be low in IDLE, SETUP and DONE.
REQ-031 Addresses SHALL never exceed FB_WIDTH*FB_HEIGHT-1 (34239 at defaults).
REQ-032 x/y counters SHALL be 8-bit; y_cur increment past 255 is impossible after clipping and needs no wrap handling.

Reset
REQ-033 While rst_sync is high on a clock edge: state=IDLE, fb_we=0, done=0, busy=0, cmd_ready=0 during reset cycle then 1 after, fb_waddr=0, fb_wdata=0, counters=0.
REQ-034 Reset mid-DRAW SHALL abort the command with no further writes and no done pulse.

Verification
REQ-035 PIXEL (5,2) colour 3'b101 -> single fb_we at addr 433, data 5, two cycles after acceptance; done next cycle.
REQ-036 RECT (10,1)-(12,2) colour 3'b010, fb_wait=0 -> writes 224,225,226,438,439,440 on consecutive cycles, then done.
REQ-037 RECT (210,158)-(255,255) -> clipped; writes 34022..34025 and 34236..34239 only (8 writes), no address >34239.
REQ-038 RECT x0=20,x1=10 -> no fb_we; done exactly 2 cycles after acceptance; reserved op same.
REQ-039 CLEAR with fb_wait toggling every other cycle -> 34240 writes, addresses 0..34239 each once in order, held stable while fb_wait=1.
REQ-040 rst_sync pulsed during CLEAR at pixel 100 -> fb_we low next cycle, no done, cmd_ready high after reset and next command executes normally.
